// File: rtl/sdram_wb_bridge_if.sv
// ============================================================================
//  Module   : sdram_wb_bridge_if
//  Purpose  : Wishbone slave bus plus sdram_controller handshake bundle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface sdram_wb_bridge_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [22:0] ctrl_addr;
   logic        ctrl_rw;
   logic [31:0] ctrl_wdata;
   logic        ctrl_in_valid;
   logic        ctrl_busy;
   logic [31:0] ctrl_rdata;
   logic        ctrl_out_valid;
   logic        timeout_o;

   // Bridge side
   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o,
      output ctrl_addr, ctrl_rw, ctrl_wdata, ctrl_in_valid,
      input  ctrl_busy, ctrl_rdata, ctrl_out_valid,
      output timeout_o
   );

   // Environment side: Wishbone master and controller
   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o,
      input  ctrl_addr, ctrl_rw, ctrl_wdata, ctrl_in_valid,
      output ctrl_busy, ctrl_rdata, ctrl_out_valid,
      input  timeout_o
   );
endinterface

`default_nettype wire

// File: rtl/sdram_wb_bridge.sv
// ============================================================================
//  Module   : sdram_wb_bridge
//  Purpose  : Single-beat Wishbone slave to sdram_controller bridge with
//             read-modify-write byte lanes and a completion watchdog.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_wb_bridge #(
   parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
   parameter logic [31:0] ADDR_MASK = 32'hFE00_0000,
   parameter int unsigned TIMEOUT   = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   sdram_wb_bridge_if.slave  bus
);

   localparam logic [2:0]  c_IDLE    = 3'd0;
   localparam logic [2:0]  c_ISSUE   = 3'd1;
   localparam logic [2:0]  c_WAIT_RD = 3'd2;
   localparam logic [2:0]  c_MERGE   = 3'd3;
   localparam logic [2:0]  c_WAIT_WR = 3'd4;
   localparam logic [2:0]  c_ACK     = 3'd5;
   localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

   logic [2:0]  r_state;
   logic        r_we;
   logic [3:0]  r_sel;
   logic [31:0] r_dat;
   logic [31:0] r_rdata;
   logic        r_abort;
   logic        r_rmw;
   logic        r_seen_busy;
   logic [15:0] r_wdog;
   logic        r_timeout;

   logic        w_hit;
   logic        w_issue_fire;
   logic        w_wdog_active;
   logic        w_expired;
   logic [31:0] w_merged;

   assign w_hit = bus.wbs_cyc_i & bus.wbs_stb_i &
                  ((bus.wbs_adr_i & ADDR_MASK) == BASE_ADDR);

   assign w_issue_fire  = (r_state == c_ISSUE) & ~bus.ctrl_busy;
   assign w_wdog_active = (r_state == c_ISSUE)   || (r_state == c_WAIT_RD) ||
                          (r_state == c_MERGE)   || (r_state == c_WAIT_WR);
   assign w_expired     = w_wdog_active && (r_wdog >= c_TIMEOUT);

   // Selected lanes take the new write data, the rest keep the SDRAM contents
   for (genvar n = 0; n < 4; n++) begin : g_merge
      assign w_merged[8*n +: 8] = r_sel[n] ? r_dat[8*n +: 8] : r_rdata[8*n +: 8];
   end

   assign bus.ctrl_in_valid = w_issue_fire;
   assign bus.wbs_ack_o     = (r_state == c_ACK) & ~r_abort;
   assign bus.wbs_dat_o     = ((r_state == c_ACK) && !r_we) ? r_rdata : 32'h0;
   assign bus.timeout_o     = r_timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= c_IDLE;
         r_we           <= 1'b0;
         r_sel          <= 4'h0;
         r_dat          <= 32'h0;
         r_rdata        <= 32'h0;
         r_abort        <= 1'b0;
         r_rmw          <= 1'b0;
         r_seen_busy    <= 1'b0;
         r_wdog         <= 16'h0;
         r_timeout      <= 1'b0;
         bus.ctrl_addr  <= 23'h0;
         bus.ctrl_rw    <= 1'b0;
         bus.ctrl_wdata <= 32'h0;
      end else begin
         // A master walking away mid-transaction only silences the ack
         if (r_state != c_IDLE && !bus.wbs_cyc_i) begin
            r_abort <= 1'b1;
         end
         if (w_wdog_active) begin
            r_wdog <= r_wdog + 16'd1;
         end

         case (r_state)
            c_IDLE: begin
               if (w_hit) begin
                  r_we           <= bus.wbs_we_i;
                  r_sel          <= bus.wbs_sel_i;
                  r_dat          <= bus.wbs_dat_i;
                  r_abort        <= 1'b0;
                  r_wdog         <= 16'h0;
                  bus.ctrl_addr  <= bus.wbs_adr_i[24:2];
                  bus.ctrl_wdata <= bus.wbs_dat_i;
                  bus.ctrl_rw    <= bus.wbs_we_i && (bus.wbs_sel_i == 4'hF);
                  r_rmw          <= bus.wbs_we_i && (bus.wbs_sel_i != 4'hF) &&
                                    (bus.wbs_sel_i != 4'h0);
                  if (bus.wbs_we_i && bus.wbs_sel_i == 4'h0) begin
                     r_state <= c_ACK;
                  end else begin
                     r_state <= c_ISSUE;
                  end
               end
            end

            c_ISSUE: begin
               // Once the request pulse is out it is committed, so it beats expiry
               if (w_issue_fire) begin
                  if (!bus.ctrl_rw) begin
                     r_state <= c_WAIT_RD;
                  end else begin
                     r_seen_busy <= 1'b0;
                     r_state     <= c_WAIT_WR;
                  end
               end else if (w_expired) begin
                  r_rdata   <= r_we ? 32'h0 : 32'hFFFF_FFFF;
                  r_timeout <= 1'b1;
                  r_state   <= c_ACK;
               end
            end

            c_WAIT_RD: begin
               if (bus.ctrl_out_valid) begin
                  r_rdata <= bus.ctrl_rdata;
                  r_state <= r_rmw ? c_MERGE : c_ACK;
               end else if (w_expired) begin
                  r_rdata   <= r_we ? 32'h0 : 32'hFFFF_FFFF;
                  r_timeout <= 1'b1;
                  r_state   <= c_ACK;
               end
            end

            c_MERGE: begin
               if (w_expired) begin
                  r_rdata   <= 32'h0;
                  r_timeout <= 1'b1;
                  r_state   <= c_ACK;
               end else begin
                  bus.ctrl_wdata <= w_merged;
                  bus.ctrl_rw    <= 1'b1;
                  r_rmw          <= 1'b0;
                  r_state        <= c_ISSUE;
               end
            end

            c_WAIT_WR: begin
               if (w_expired) begin
                  r_rdata   <= 32'h0;
                  r_timeout <= 1'b1;
                  r_state   <= c_ACK;
               end else begin
                  if (bus.ctrl_busy) begin
                     r_seen_busy <= 1'b1;
                  end
                  if (r_seen_busy && !bus.ctrl_busy) begin
                     r_state <= c_ACK;
                  end
               end
            end

            c_ACK: begin
               r_state <= c_IDLE;
            end

            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
